// File: rtl/id_ex_stage.sv
// ID/EX pipeline register and operand-forwarding stage.
//
// Registers the decoded instruction coming out of ID and presents it to the
// ALU one cycle later. The ALU operands are forwarded combinationally from
// EX/MEM (first priority) or MEM/WB (second priority). x0 is never forwarded.
// A load sitting in EX whose destination is read by the instruction in ID
// raises load_use_stall and turns the next EX slot into a bubble.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   stall               global freeze: hold every EX register
//   flush               kill the instruction entering EX (taken branch/jump)
//   id_*                decoded instruction fields from ID
//   ex_mem_*, mem_wb_*  destination/result of the two downstream stages
//   ex_valid            EX holds a real instruction
//   alu_sel, dataA,
//   dataB               ALU opcode and operands
//   ex_rs2_fwd          forwarded rs2 (store data), independent of b_sel
//   ex_rd_addr,
//   ex_reg_wen,
//   ex_mem_read         registered destination, write enable, load flag
//   load_use_stall      combinational; ID/IF must hold this cycle
module id_ex_stage #(
  parameter int REG_WIDTH  = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  id_valid,
  input  logic [2:0]            id_alu_sel,
  input  logic [ADDR_WIDTH-1:0] id_rs1_addr,
  input  logic [ADDR_WIDTH-1:0] id_rs2_addr,
  input  logic                  id_rs2_used,
  input  logic [REG_WIDTH-1:0]  id_rs1_data,
  input  logic [REG_WIDTH-1:0]  id_rs2_data,
  input  logic [REG_WIDTH-1:0]  id_imm,
  input  logic                  id_b_sel,
  input  logic [ADDR_WIDTH-1:0] id_rd_addr,
  input  logic                  id_reg_wen,
  input  logic                  id_mem_read,
  input  logic [ADDR_WIDTH-1:0] ex_mem_rd_addr,
  input  logic                  ex_mem_reg_wen,
  input  logic [REG_WIDTH-1:0]  ex_mem_alu_out,
  input  logic [ADDR_WIDTH-1:0] mem_wb_rd_addr,
  input  logic                  mem_wb_reg_wen,
  input  logic [REG_WIDTH-1:0]  mem_wb_wdata,
  output logic                  ex_valid,
  output logic [2:0]            alu_sel,
  output logic [REG_WIDTH-1:0]  dataA,
  output logic [REG_WIDTH-1:0]  dataB,
  output logic [REG_WIDTH-1:0]  ex_rs2_fwd,
  output logic [ADDR_WIDTH-1:0] ex_rd_addr,
  output logic                  ex_reg_wen,
  output logic                  ex_mem_read,
  output logic                  load_use_stall
);

  // EX register state
  logic                  valid_reg,    valid_next;
  logic [2:0]            alu_sel_reg,  alu_sel_next;
  logic [ADDR_WIDTH-1:0] rs1_addr_reg, rs1_addr_next;
  logic [ADDR_WIDTH-1:0] rs2_addr_reg, rs2_addr_next;
  logic [REG_WIDTH-1:0]  rs1_data_reg, rs1_data_next;
  logic [REG_WIDTH-1:0]  rs2_data_reg, rs2_data_next;
  logic [REG_WIDTH-1:0]  imm_reg,      imm_next;
  logic                  b_sel_reg,    b_sel_next;
  logic [ADDR_WIDTH-1:0] rd_addr_reg,  rd_addr_next;
  logic                  reg_wen_reg,  reg_wen_next;
  logic                  mem_read_reg, mem_read_next;

  // A load in EX cannot forward its data until it reaches MEM/WB, so a
  // dependent instruction in ID must wait one cycle.
  assign load_use_stall = valid_reg && mem_read_reg && (rd_addr_reg != '0) && id_valid &&
                          ((id_rs1_addr == rd_addr_reg) ||
                           (id_rs2_used && (id_rs2_addr == rd_addr_reg)));

  // Update priority: flush > stall > load-use bubble > capture.
  // A bubble only clears the control bits; the data fields keep their old
  // values so the datapath stays deterministic.
  always_comb begin
    valid_next    = valid_reg;
    alu_sel_next  = alu_sel_reg;
    rs1_addr_next = rs1_addr_reg;
    rs2_addr_next = rs2_addr_reg;
    rs1_data_next = rs1_data_reg;
    rs2_data_next = rs2_data_reg;
    imm_next      = imm_reg;
    b_sel_next    = b_sel_reg;
    rd_addr_next  = rd_addr_reg;
    reg_wen_next  = reg_wen_reg;
    mem_read_next = mem_read_reg;
    if (flush || (!stall && load_use_stall)) begin
      valid_next    = 1'b0;
      reg_wen_next  = 1'b0;
      mem_read_next = 1'b0;
    end else if (!stall) begin
      valid_next    = id_valid;
      alu_sel_next  = id_alu_sel;
      rs1_addr_next = id_rs1_addr;
      rs2_addr_next = id_rs2_addr;
      rs1_data_next = id_rs1_data;
      rs2_data_next = id_rs2_data;
      imm_next      = id_imm;
      b_sel_next    = id_b_sel;
      rd_addr_next  = id_rd_addr;
      reg_wen_next  = id_reg_wen && id_valid;
      mem_read_next = id_mem_read && id_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_reg    <= 1'b0;
      alu_sel_reg  <= 3'b000;
      rs1_addr_reg <= '0;
      rs2_addr_reg <= '0;
      rs1_data_reg <= '0;
      rs2_data_reg <= '0;
      imm_reg      <= '0;
      b_sel_reg    <= 1'b0;
      rd_addr_reg  <= '0;
      reg_wen_reg  <= 1'b0;
      mem_read_reg <= 1'b0;
    end else begin
      valid_reg    <= valid_next;
      alu_sel_reg  <= alu_sel_next;
      rs1_addr_reg <= rs1_addr_next;
      rs2_addr_reg <= rs2_addr_next;
      rs1_data_reg <= rs1_data_next;
      rs2_data_reg <= rs2_data_next;
      imm_reg      <= imm_next;
      b_sel_reg    <= b_sel_next;
      rd_addr_reg  <= rd_addr_next;
      reg_wen_reg  <= reg_wen_next;
      mem_read_reg <= mem_read_next;
    end
  end

  // Operand forwarding, one identical mux per source operand
  // (index 0 = rs1, index 1 = rs2).
  logic [ADDR_WIDTH-1:0] src_addr [2];
  logic [REG_WIDTH-1:0]  src_data [2];
  logic [REG_WIDTH-1:0]  fwd_data [2];

  assign src_addr[0] = rs1_addr_reg;
  assign src_addr[1] = rs2_addr_reg;
  assign src_data[0] = rs1_data_reg;
  assign src_data[1] = rs2_data_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      logic hit_ex_mem;
      logic hit_mem_wb;
      assign hit_ex_mem = ex_mem_reg_wen && (ex_mem_rd_addr != '0) &&
                          (ex_mem_rd_addr == src_addr[gi]);
      assign hit_mem_wb = mem_wb_reg_wen && (mem_wb_rd_addr != '0) &&
                          (mem_wb_rd_addr == src_addr[gi]);
      // EX/MEM holds the younger result, so it wins over MEM/WB.
      assign fwd_data[gi] = hit_ex_mem ? ex_mem_alu_out :
                            hit_mem_wb ? mem_wb_wdata   :
                                         src_data[gi];
    end
  endgenerate

  assign ex_valid    = valid_reg;
  assign alu_sel     = alu_sel_reg;
  assign dataA       = fwd_data[0];
  assign dataB       = b_sel_reg ? imm_reg : fwd_data[1];
  assign ex_rs2_fwd  = fwd_data[1];
  assign ex_rd_addr  = rd_addr_reg;
  assign ex_reg_wen  = reg_wen_reg;
  assign ex_mem_read = mem_read_reg;

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register and operand-forwarding stage of the RISC-V core; sits directly upstream of the ALU.
- Captures decoded operands and control from ID, resolves EX/MEM and MEM/WB data hazards, and drives the ALU's alu_sel/dataA/dataB.
- Detects load-use hazards and inserts a bubble; honours a global pipeline stall and a branch/jump flush.

Parameters:
REG_WIDTH, 32, datapath width; must match the ALU.
ADDR_WIDTH, 5, register-file address width.

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  synchronous active-low reset
stall  input  1  global freeze; all stages hold
flush  input  1  kill the instruction entering EX (taken branch/jump)
id_valid  input  1  ID holds a real instruction
id_alu_sel  input  3  ALU op code (000 ADD … 111 SRA)
id_rs1_addr  input  ADDR_WIDTH  source 1 index
id_rs2_addr  input  ADDR_WIDTH  source 2 index
id_rs2_used  input  1  instruction reads rs2 (R-type/store/branch)
id_rs1_data  input  REG_WIDTH  register-file read 1
id_rs2_data  input  REG_WIDTH  register-file read 2
id_imm  input  REG_WIDTH  sign-extended immediate
id_b_sel  input  1  1: dataB = immediate, 0: dataB = rs2
id_rd_addr  input  ADDR_WIDTH  destination index
id_reg_wen  input  1  instruction writes rd
id_mem_read  input  1  instruction is a load
ex_mem_rd_addr  input  ADDR_WIDTH  EX/MEM destination
ex_mem_reg_wen  input  1  EX/MEM writes rd
ex_mem_alu_out  input  REG_WIDTH  EX/MEM result
mem_wb_rd_addr  input  ADDR_WIDTH  MEM/WB destination
mem_wb_reg_wen  input  1  MEM/WB writes rd
mem_wb_wdata  input  REG_WIDTH  MEM/WB write-back value
ex_valid  output  1  EX holds a real instruction
alu_sel  output  3  to ALU
dataA  output  REG_WIDTH  to ALU, forwarded rs1
dataB  output  REG_WIDTH  to ALU, immediate or forwarded rs2
ex_rs2_fwd  output  REG_WIDTH  forwarded rs2 (store data)
ex_rd_addr  output  ADDR_WIDTH  registered destination
ex_reg_wen  output  1  registered write enable, gated by ex_valid
ex_mem_read  output  1  registered load flag, gated by ex_valid
load_use_stall  output  1  combinational; ID/IF must hold this cycle

Behaviour:
- Reset (rst_n=0 at clk edge): all EX registers clear. ex_valid=0, alu_sel=000, rd/rs addresses=0, data/imm=0, b_sel=0, ex_reg_wen=0, ex_mem_read=0. Reset overrides stall and flush.
- load_use_stall = ex_valid & ex_mem_read & (ex_rd_addr!=0) & id_valid & ((id_rs1_addr==ex_rd_addr) | (id_rs2_used & id_rs2_addr==ex_rd_addr)).
- Register update priority per edge: reset > flush (bubble) > stall (hold all) > load_use_stall (bubble) > capture ID.
- Bubble: ex_valid=0, ex_reg_wen=0, ex_mem_read=0; other fields don't-care but deterministic (hold).
- Capture: all id_* fields are registered; ex_valid=id_valid; ex_reg_wen=id_reg_wen&id_valid; ex_mem_read=id_mem_read&id_valid.
- Latency: ID fields appear on ALU inputs one cycle after capture.
- Forwarding is combinational from the EX registers; it is evaluated independently for rs1 and rs2:
  - First priority: EX/MEM, when ex_mem_reg_wen & ex_mem_rd_addr!=0 & address match → ex_mem_alu_out.
  - Second: MEM/WB, under the same conditions with mem_wb_* → mem_wb_wdata.
  - Otherwise: the registered register-file data.
  - x0 is never forwarded.
- dataA = forwarded rs1; dataB = ex_b_sel ? ex_imm : forwarded rs2; ex_rs2_fwd = forwarded rs2 regardless of b_sel.
- The same-cycle WB-write/ID-read hazard is resolved by the register file (write-before-read), not here.
- During stall, forwarding stays active; upstream stages are frozen too, so sources are stable.
- Flush together with load_use_stall: bubble. The ID instruction is refetched by the branch logic.

Test Plan:
- Reset: hold rst_n=0 with stall=1, flush=1 and valid ID inputs → after edge ex_valid=0, ex_reg_wen=0, alu_sel=000, dataA=0.
- Back-to-back ADD: x1=5 written (EX/MEM rd=1, out=5) and MEM/WB rd=1 wdata=9 simultaneously; EX instr rs1=1 → dataA=5 (EX/MEM wins). With EX/MEM rd=0, out=7, rs1=0, reg data 0 → dataA=0.
- Load-use: EX has lw rd=3 ex_mem_read=1; ID has add rs2=3, rs2_used=1 → load_use_stall=1, next cycle ex_valid=0, ex_reg_wen=0. With id_rs2_used=0 and rs1≠3 → no stall.
- Immediate select: id_b_sel=1, imm=0xFFFFFFFC, rs2 forwarded value 0x10 → dataB=0xFFFFFFFC, ex_rs2_fwd=0x10.
- Stall then flush: capture alu_sel=101; stall for 3 cycles with changing id_* → outputs unchanged. Then flush=1 with stall=1 → ex_valid=0 (flush wins).
- Reset mid-stream: rst_n=0 for one edge while ex_valid=1, ex_reg_wen=1 → both 0 next cycle. Then pipeline resumes capture on the first edge with rst_n=1.
